spart_tx: RTL and testbench
===========================

Name: spart_tx

Overview:
SPART transmit stage, directly downstream of the SPART bus interface. Consumes the tx_write strobe and the byte on the shared 8-bit databus, and returns tbr (transmit buffer ready) for the status register. Holds one byte in a holding register and serialises it on txd as 8N1 UART frames. The baud period is set by a divisor parameter.

Parameters:
BAUD_DIV, 434, clocks per serial bit (50 MHz / 115200); legal range is 2 and up.
CNT_W, $clog2(BAUD_DIV), width of the baud counter; derived, do not override.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
tx_write  input  1  one-cycle write strobe from the bus interface
databus  input  8  byte to transmit; sampled when tx_write=1
tbr  output  1  1 = holding register empty and a write will be accepted
tx_busy  output  1  1 = a frame is on the line (state is not IDLE)
txd  output  1  serial output; idles high

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active low.
- Reset values:
  - txd=1, tbr=1, tx_busy=0.
  - State IDLE, holding register empty, baud counter 0, bit index 0.
- Holding register:
  - Accepting a write: tx_write=1 while tbr=1 captures databus on that edge. tbr=0 from the next cycle.
  - Dropped write: tx_write=1 while tbr=0 is ignored. The holding register is unchanged and no error is flagged.
- Transfer:
  - Trigger: state IDLE and holding register full.
  - On that edge: holding register moves to the shift register, state goes to START, baud counter loads BAUD_DIV-1.
  - tbr returns to 1 in the cycle after the transfer edge.
- Latency: tx_write in cycle N (idle line) gives tbr=0 in cycle N+1, and txd=0 (start bit) plus tbr=1 in cycle N+2.
- Simultaneous events: a write in the transfer cycle sees tbr=0 and is dropped. Writes are accepted only when tbr=1.
- FSM states:
  - IDLE: txd=1.
  - START: txd=0.
  - DATA: txd = shift[0]; 8 bits, LSB first.
  - STOP: txd=1.
- Baud counting:
  - Each state bit lasts exactly BAUD_DIV clocks. The counter counts down from BAUD_DIV-1 and the bit ends when it reaches 0.
  - At the end of a DATA bit: shift right and increment the bit index. After index 7, go to STOP.
- End of STOP:
  - Holding register full: transfer on the same edge and go straight to START. No idle gap, so back-to-back frames are contiguous.
  - Holding register empty: go to IDLE.
- Frame length: exactly 10*BAUD_DIV clocks.
- Output timing: txd is registered (no combinational path from inputs). tx_busy is registered and high in START, DATA and STOP.
- Reset mid-frame: txd goes to 1 and tbr to 1 immediately (asynchronously). The pending byte and the in-flight frame are discarded.
- databus is don't-care when tx_write=0.

Optional Feature:
Macro SPART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity), held for BAUD_DIV clocks.
  - Frame length becomes 11*BAUD_DIV clocks.
- Undefined: no PARITY state; 8N1 framing and 10*BAUD_DIV frames exactly as above.

Test Plan:
1. Reset: hold rst_n=0 with tx_write toggling -> txd=1, tbr=1, tx_busy=0 throughout. First release cycle shows the same values.
2. Single byte, BAUD_DIV=4: write 0xA5 at cycle N -> tbr=0 at N+1. From N+2, txd emits 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tbr=1 from N+2; tx_busy=1 for 40 cycles, then 0.
3. Back-to-back, BAUD_DIV=4: write 0x55, then 0x0F as soon as tbr=1 -> the second frame's start bit begins in the cycle right after the first stop bit ends. txd bits for the second frame are 0,1,1,1,1,0,0,0,0,1. tbr falls after the second write and rises at the second frame's start bit.
4. Dropped write, BAUD_DIV=4: write 0x11, then 0x22 while tbr=0 and still IDLE, then 0x33 once tbr=1 -> line carries 0x11 then 0x33; 0x22 never appears.
5. Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF -> txd=1 in the same cycle, before the next clk edge. After release, the line stays idle with no resumed frame.
6. With SPART_TX_PARITY_EN, BAUD_DIV=4: send 0x07 -> parity bit 1 before the stop bit, frame is 44 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/spart_tx.sv
// SPART transmit stage: one-byte holding register feeding an 8N1 UART serialiser.
// Optional even-parity bit between data and stop when SPART_TX_PARITY_EN is defined.
module spart_tx #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_write,
  input  logic [7:0] databus,
  output logic       tbr,
  output logic       tx_busy,
  output logic       txd
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             load;
  logic             bit_end;
`ifdef SPART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == '0);
  assign tbr     = ~hold_full_q;
  assign tx_busy = busy_q;
  assign txd     = txd_q;

  // State, holding/shift registers and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SPART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
`ifdef SPART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state: write capture, baud counting, bit sequencing and hold->shift transfer.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    load        = 1'b0;
`ifdef SPART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Writes while the holding register is full are silently dropped.
    if (tx_write && !hold_full_q) begin
      hold_d      = databus;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          cnt_d     = CntLoad;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = CntLoad;
          if (bit_idx_q == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SPART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = CntLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          // A pending byte starts immediately so back-to-back frames have no gap.
          if (hold_full_q) load = 1'b1;
          else             state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = StStart;
      cnt_d       = CntLoad;
      bit_idx_d   = '0;
`ifdef SPART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end
  end

  // Line outputs are decoded from the next state so txd/tx_busy come straight from flops.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx (BAUD_DIV=4): timing model + frame scoreboard.
// Define SPART_TX_PARITY_EN for both RTL and bench to exercise the parity frame.
module tb_spart_tx;

  localparam int Baud = 4;
`ifdef SPART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int FrameCyc = NBits * Baud;

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_write = 1'b0;
  logic [7:0] databus = 8'h00;
  logic       tbr, tx_busy, txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, all in absolute cycle numbers.
  frame_t exp_q[$];
  int     starts[$];
  int     hold_start = 0;   // tbr is 1 from this cycle on
  int     line_free  = 0;   // first cycle after the last scheduled frame
  int     tbr_lo = 1, tbr_hi = 0;

  // Monitor state.
  logic   mon_active = 1'b0;
  int     mon_off = 0;
  frame_t cur;

  spart_tx #(.BAUD_DIV(Baud)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_write (tx_write),
    .databus  (databus),
    .tbr      (tbr),
    .tx_busy  (tx_busy),
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Expected line level for bit k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef SPART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int c);
    foreach (starts[i]) if (c >= starts[i] && c < starts[i] + FrameCyc) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: pops a frame when its start cycle arrives and checks every line cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      chk("reset_txd", txd, 1'b1);
      chk("reset_tbr", tbr, 1'b1);
      chk("reset_busy", tx_busy, 1'b0);
    end else begin
      if (!mon_active && exp_q.size() > 0 && exp_q[0].start == cyc) begin
        cur        = exp_q.pop_front();
        mon_active = 1'b1;
        mon_off    = 0;
      end
      if (mon_active) begin
        chk("txd_frame_bit", txd, frame_bit(cur.data, mon_off / Baud));
        mon_off++;
        if (mon_off == FrameCyc) mon_active = 1'b0;
      end else begin
        chk("txd_idle", txd, 1'b1);
      end
      chk("tbr", tbr, !(cyc >= tbr_lo && cyc <= tbr_hi));
      chk("tx_busy", tx_busy, model_busy(cyc));
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one write strobe; the model decides acceptance from its own tbr prediction.
  task automatic send(input logic [7:0] b);
    int n, st;
    n        = cyc;
    tx_write = 1'b1;
    databus  = b;
    if (n >= hold_start) begin
      st = (n + 2 > line_free) ? n + 2 : line_free;
      exp_q.push_back('{start: st, data: b});
      starts.push_back(st);
      tbr_lo     = n + 1;
      tbr_hi     = st - 1;
      hold_start = st;
      line_free  = st + FrameCyc;
    end
    tick(1);
    tx_write = 1'b0;
    databus  = 8'($urandom);
  endtask

  task automatic wait_tbr();
    while (cyc < hold_start) tick(1);
  endtask

  task automatic wait_idle();
    while (cyc < line_free + 1) tick(1);
  endtask

  initial begin
    int st;
    // Reset with write strobes toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      tx_write = i[0];
      databus  = 8'($urandom);
    end
    tx_write = 1'b0;
    #2 rst_n = 1'b1;
    tick(3);

    // Single byte.
    send(8'hA5);
    wait_idle();

    // Back-to-back frames.
    send(8'h55);
    wait_tbr();
    send(8'h0F);
    wait_idle();

    // Dropped write while holding register full.
    send(8'h11);
    send(8'h22);
    wait_tbr();
    send(8'h33);
    wait_idle();

    // Parity-relevant bytes.
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();

    // Randomised traffic, mixing waits for tbr with blind writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) wait_tbr();
      tick($urandom_range(0, 6));
      send(8'($urandom));
    end
    wait_idle();

    // Reset during data bit 3 of 0xFF.
    send(8'hFF);
    st = hold_start;
    while (cyc < st + 4 * Baud + 1) tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1'b1);
    chk("async_reset_tbr", tbr, 1'b1);
    exp_q.delete();
    starts.delete();
    hold_start = 0;
    line_free  = 0;
    tbr_lo     = 1;
    tbr_hi     = 0;
    tick(2);
    rst_n = 1'b1;
    tick(3 * FrameCyc);

    // Line usable again after the aborted frame.
    send(8'h3C);
    wait_idle();
    tick(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_left: got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
